// File: rtl/st_unpack_pkg.sv
// st_unpack_pkg: beat field offsets and FSM states shared by the symbol unpacker
package st_unpack_pkg;
  localparam int DATA_MSB  = 36;
  localparam int DATA_LSB  = 5;
  localparam int EMPTY_MSB = 4;
  localparam int EMPTY_LSB = 3;
  localparam int SOP_BIT   = 2;
  localparam int EOP_BIT   = 1;
  localparam int ERR_BIT   = 0;
  typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/st_beat_to_symbol_unpacker.sv
// st_beat_to_symbol_unpacker: splits FIFO beats into big-endian symbols, one per cycle, with packet sideband
module st_beat_to_symbol_unpacker
  import st_unpack_pkg::*;
#(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int EMPTY_WIDTH      = 2,
  parameter int IN_WIDTH         = SYMBOL_WIDTH*SYMBOLS_PER_BEAT + EMPTY_WIDTH + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket,
  output logic                    out_error
);
  localparam int DW = SYMBOL_WIDTH*SYMBOLS_PER_BEAT;
  localparam logic [EMPTY_WIDTH-1:0] LAST_FULL = EMPTY_WIDTH'(SYMBOLS_PER_BEAT-1);
  state_e state_q, state_d;
  logic [DW-1:0] data_q, data_d, shifted;
  logic [EMPTY_WIDTH-1:0] idx_q, idx_d, last_q, last_d;
  logic sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d, out_err_q, out_err_d;
  logic [SYMBOL_WIDTH-1:0] out_data_q, out_data_d;
  logic adv, last, load, step, upd;
  // last_q holds the index of the final symbol of the held beat, so empty need not be kept
  always_comb begin
    adv         = !out_valid_q || out_ready;
    last        = state_q == SHIFT && idx_q == last_q;
    in_ready    = state_q == IDLE || (last && adv);
    load        = in_valid && in_ready;
    step        = state_q == SHIFT && adv && !last;
    upd         = load || step;
    data_d      = load ? in_data[DATA_LSB +: DW] : data_q;
    sop_d       = load ? in_data[SOP_BIT] : sop_q;
    eop_d       = load ? in_data[EOP_BIT] : eop_q;
    err_d       = load ? in_data[ERR_BIT] : err_q;
    last_d      = load ? (in_data[EOP_BIT] ? LAST_FULL - in_data[EMPTY_LSB +: EMPTY_WIDTH] : LAST_FULL) : last_q;
    idx_d       = load ? '0 : step ? idx_q + EMPTY_WIDTH'(1) : idx_q;
    state_d     = load ? SHIFT : (last && adv) ? IDLE : state_q;
    shifted     = data_d >> (SYMBOL_WIDTH*(SYMBOLS_PER_BEAT-1-int'(idx_d)));
    out_valid_d = upd || (out_valid_q && !adv);
    out_data_d  = upd ? shifted[SYMBOL_WIDTH-1:0] : out_data_q;
    out_sop_d   = upd ? sop_d && idx_d == '0 : out_sop_q;
    out_eop_d   = upd ? eop_d && idx_d == last_d : out_eop_q;
    out_err_d   = upd ? err_d : out_err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
    end
  end
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_error         = out_err_q;
endmodule

// File: tb/tb_st_beat_to_symbol_unpacker.sv
// tb_st_beat_to_symbol_unpacker: directed and randomized checks against a queue-based symbol model
module tb_st_beat_to_symbol_unpacker;
  logic clk = 0, reset = 1, in_valid = 0, in_ready;
  logic [36:0] in_data = '0;
  logic out_valid, out_ready, out_sop, out_eop, out_err;
  logic [7:0] out_data;
  logic dir_ready = 1, rnd_ready = 1, rnd_en = 0, mon_en = 0;
  int checks = 0, failures = 0;
  int exp_sop = 0, exp_eop = 0, got_sop = 0, got_eop = 0;
  typedef struct packed {logic [7:0] d; logic s, e, r;} sym_t;
  sym_t exp_q[$];

  assign out_ready = rnd_en ? rnd_ready : dir_ready;
  always #5 clk = ~clk;

  st_beat_to_symbol_unpacker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_error(out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] mk(input logic [31:0] d, input logic [1:0] emp, input logic s, input logic e, input logic r);
    return {d, emp, s, e, r};
  endfunction

  // expected symbols of one beat, derived from the packet rules
  task automatic model_push(input logic [36:0] b);
    int n;
    logic [31:0] w;
    n = b[1] ? 4 - int'(b[4:3]) : 4;
    w = b[36:5];
    for (int i = 0; i < n; i++) begin
      sym_t t;
      t.d = 8'(w >> (8*(3-i)));
      t.s = b[2] && i == 0;
      t.e = b[1] && i == n-1;
      t.r = b[0];
      exp_sop += int'(t.s);
      exp_eop += int'(t.e);
      exp_q.push_back(t);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_extra_symbol", 64'(exp_q.size()), 1);
      else check("sb_symbol", {out_data, out_sop, out_eop, out_err}, exp_q.pop_front());
      got_sop += int'(out_sop);
      got_eop += int'(out_eop);
    end
    if (in_valid && in_ready) model_push(in_data);
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = $urandom_range(0, 3) != 0;
  end

  // called and returns at posedge+1; holds the beat until it is accepted
  task automatic send(input logic [36:0] b);
    int k;
    in_valid = 1;
    in_data = b;
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 200);
    check("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w1;
    logic [47:0] exp6;
    logic [3:0] pat;
    logic [7:0] t3e [6];
    logic in_pkt, s, e, r;
    logic [1:0] emp;
    int k, gap;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 0;
    mon_en = 1;

    @(posedge clk); #1;
    w1 = 32'hA1B2C3D4;
    in_valid = 1;
    in_data = mk(w1, 0, 1, 1, 0);
    @(negedge clk);
    check("t1_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, w1[31-8*i -: 8]);
      check("t1_sop", out_sop, i == 0);
      check("t1_eop", out_eop, i == 3);
      check("t1_in_ready", in_ready, i == 3);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t1_drop", out_valid, 0);

    @(posedge clk); #1;
    fork
      begin
        send(mk(32'h11223344, 0, 1, 0, 0));
        send(mk(32'h55667788, 2, 0, 1, 0));
      end
      begin
        exp6 = 48'h112233445566;
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 20);
        for (int i = 0; i < 6; i++) begin
          if (i > 0) @(negedge clk);
          check("t2_valid", out_valid, 1);
          check("t2_data", out_data, exp6[47-8*i -: 8]);
          check("t2_eop", out_eop, i == 5);
        end
        @(negedge clk);
        check("t2_drop", out_valid, 0);
      end
    join

    @(posedge clk); #1;
    pat = 4'b1001;
    t3e = '{8'hC0, 8'hC1, 8'hC1, 8'hC1, 8'hC2, 8'hC3};
    send(mk(32'hC0C1C2C3, 0, 1, 1, 0));
    for (int i = 0; i < 6; i++) begin
      dir_ready = i < 4 ? pat[i] : 1'b1;
      @(negedge clk);
      check("t3_valid", out_valid, 1);
      check("t3_data", out_data, t3e[i]);
      @(posedge clk); #1;
    end
    dir_ready = 1;
    @(negedge clk);
    check("t3_drop", out_valid, 0);

    @(posedge clk); #1;
    send(mk(32'hEE000000, 3, 1, 1, 1));
    in_valid = 1;
    in_data = mk(32'h12345678, 0, 1, 1, 0);
    @(negedge clk);
    check("t4_data", out_data, 8'hEE);
    check("t4_sop", out_sop, 1);
    check("t4_eop", out_eop, 1);
    check("t4_err", out_err, 1);
    check("t4_next_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("t4_next_data", out_data, 8'h12);
    check("t4_next_err", out_err, 0);
    repeat (5) @(posedge clk);
    #1;

    send(mk(32'hAABBCCDD, 0, 1, 1, 0));
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t5_pre_data", out_data, 8'hCC);
    mon_en = 0;
    reset = 1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_data", out_data, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    mon_en = 1;
    @(negedge clk);
    check("t5_no_resume", out_valid, 0);
    @(posedge clk); #1;
    send(mk(32'h01020304, 0, 1, 1, 0));
    @(negedge clk);
    check("t5_first_data", out_data, 8'h01);
    check("t5_first_sop", out_sop, 1);
    repeat (5) @(posedge clk);
    #1;

    exp_sop = 0; exp_eop = 0; got_sop = 0; got_eop = 0;
    rnd_en = 1;
    in_pkt = 0;
    for (int b = 0; b < 1000; b++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      s = !in_pkt;
      e = (b == 999) || ($urandom_range(0, 2) == 0);
      emp = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 7) == 0;
      send(mk($urandom, emp, s, e, r));
      in_pkt = !e;
    end
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin @(posedge clk); k++; end
    @(negedge clk);
    check("t6_drain", 64'(exp_q.size()), 0);
    check("t6_sop_count", 64'(got_sop), 64'(exp_sop));
    check("t6_eop_count", 64'(got_eop), 64'(exp_eop));
    check("t6_sop_eq_eop", 64'(got_sop), 64'(got_eop));
    rnd_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/st_beat_to_symbol_unpacker.md
Name: st_beat_to_symbol_unpacker

Overview:
- Avalon-ST width down-converter sitting directly downstream of the timing-adapter FIFO.
- Consumes 37-bit FIFO beats (32-bit data, 4 symbols, plus packet sideband) and emits one 8-bit symbol per cycle with sop/eop/error.
- Feeds the byte-wide consumer, e.g. a UART/JTAG streaming sink.
- Ready latency 0 on both interfaces.

Parameters:
- SYMBOL_WIDTH, 8, bits per output symbol
- SYMBOLS_PER_BEAT, 4, symbols packed in one input beat
- EMPTY_WIDTH, 2, width of the empty field; equals log2(SYMBOLS_PER_BEAT)
- IN_WIDTH, 37, SYMBOL_WIDTH*SYMBOLS_PER_BEAT + EMPTY_WIDTH + 3

Ports:
- clk  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  beat valid from FIFO out_valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  IN_WIDTH  beat; field layout below
- out_valid  output  1  symbol valid (registered)
- out_ready  input  1  downstream ready
- out_data  output  SYMBOL_WIDTH  current symbol (registered)
- out_startofpacket  output  1  first symbol of packet
- out_endofpacket  output  1  last symbol of packet
- out_error  output  1  error flag of the originating beat

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-high, port names clk and reset.
- in_data layout:
  - [36:5] data; symbol 0 = [36:29] goes out first (big-endian).
  - [4:3] empty.
  - [2] sop.
  - [1] eop.
  - [0] error.
- Reset values:
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_error=0.
  - Internal state IDLE; symbol index 0.
- States:
  - IDLE: no beat held; in_ready=1.
  - SHIFT: a beat is held; symbols are emitted from a holding register.
- Symbol count per beat:
  - n = SYMBOLS_PER_BEAT - empty when eop=1; empty=0 yields 4.
  - n = SYMBOLS_PER_BEAT when eop=0; empty is ignored.
- Accept:
  - The beat is captured into the holding register and index idx=0.
  - The symbol at idx is driven to the output registers: out_valid=1 on the cycle after acceptance (latency 1).
- Advance:
  - Output registers update when !out_valid || out_ready.
  - If the current symbol is the last (idx==n-1), in_ready is combinationally 1 in SHIFT that cycle, so the next beat loads with no bubble.
  - Otherwise idx increments.
- Throughput: sustained 1 symbol/cycle with out_ready=1 and in_valid=1.
- Sideband per symbol:
  - sop only on idx 0 of a beat with sop=1.
  - eop only on idx n-1 of a beat with eop=1.
  - error copied to every symbol of the beat.
- Last symbol consumed and in_valid=0: go to IDLE; out_valid drops the next cycle.
- Backpressure: while out_valid && !out_ready, out_data and the sideband are held stable and idx does not advance.
- in_ready is 0 in SHIFT unless the last symbol is being consumed in this cycle.
- Single-symbol beat (eop=1, empty=3): n=1; emitted with sop and eop if both are set.
- Reset asserted mid-packet: the held beat is discarded and all outputs return to their reset values immediately. No partial symbols resume after reset.

Decomposition:
- Shared package st_unpack_pkg:
  - Field offsets: DATA_MSB=36, DATA_LSB=5, EMPTY_MSB=4, EMPTY_LSB=3, SOP_BIT=2, EOP_BIT=1, ERR_BIT=0.
  - State enum {IDLE, SHIFT}.
- No sub-module: a single FSM, holding register and symbol counter.

Test Plan:
- Single beat data=32'hA1B2C3D4, sop=1, eop=1, empty=0, out_ready=1:
  - Symbols A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after accept.
  - sop on A1, eop on D4.
  - in_ready=0 for the 3 middle cycles.
- Back-to-back beats 11223344 (sop) then 55667788 (eop, empty=2):
  - Output 11,22,33,44,55,66 with no bubble.
  - eop on 66; 77 and 88 are never emitted.
- out_ready toggling 1,0,0,1 during a beat:
  - out_data held unchanged while ready=0.
  - No symbol is duplicated or dropped; checked by scoreboard.
- eop beat with empty=3, data=32'hEE000000, error=1:
  - Exactly one symbol EE with eop=1 and error=1.
  - Next beat accepted the following cycle.
- Reset pulsed after the 2nd symbol of a 4-symbol beat:
  - out_valid=0 asynchronously.
  - After release, a new beat 0x01020304 emits 01 first.
- Random valid/ready for 1000 beats, chained behind the timing-adapter FIFO:
  - Symbol order matches the reference model.
  - sop/eop counts are equal.
